// File: rtl/reg_bank_pkg.sv
// Shared constants, address-width helper and pending-vector type for the register bank.
package reg_bank_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefDepth = 8;

    // Width of an address that selects one of 'depth' registers.
    function automatic int unsigned addr_w(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [DefDepth-1:0] pending_vec_t;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-register pending scoreboard: reserve sets, write clears, sticky error on double reserve.
module reg_bank_scoreboard
    import reg_bank_pkg::*;
#(
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned ADDR_W   = addr_w(DEPTH),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  pending,
    output logic              rsv_err
);

    logic [DEPTH-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    logic             wr_ok, rsv_ok;

    assign wr_ok  = wr_en && !(ZERO_REG && wr_addr == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

    // Clear before set so a same-edge write and reserve leave the register pending.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (wr_ok) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            if (pending_q[rsv_addr]) begin
                err_d = 1'b1;
            end
            pending_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending = pending_q;
    assign rsv_err = err_q;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: one write port, two registered read ports, pending scoreboard.
// Optional macro REG_BANK_BYPASS_EN forwards same-edge write data into the read ports.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = DefDepth,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W  = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rda_sel,
    input  logic [ADDR_W-1:0] rdb_sel,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              a_pending,
    output logic              b_pending,
    output logic              rsv_err
);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             pending;
    logic                         wr_ok;

    logic [ADDR_W-1:0] rd_sel  [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_pend [2];

    logic [DATA_W-1:0] reg_a_q, reg_b_q;
    logic              a_pend_q, b_pend_q;

    reg_bank_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pending  (pending),
        .rsv_err  (rsv_err)
    );

    assign wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_sel[0] = rda_sel;
    assign rd_sel[1] = rdb_sel;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_sel[p]];
            rd_pend[p] = pending[rd_sel[p]];
`ifdef REG_BANK_BYPASS_EN
            if (wr_en && wr_addr == rd_sel[p]) begin
                rd_data[p] = wr_data;
                rd_pend[p] = rsv_en && rsv_addr == rd_sel[p];
            end
`endif
            // R0 reads as zero regardless of forwarding.
            if (ZERO_REG && rd_sel[p] == '0) begin
                rd_data[p] = '0;
                rd_pend[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
        end else if (rd_en) begin
            reg_a_q  <= rd_data[0];
            reg_b_q  <= rd_data[1];
            a_pend_q <= rd_pend[0];
            b_pend_q <= rd_pend[1];
        end
    end

    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign a_pending = a_pend_q;
    assign b_pending = b_pend_q;

endmodule
